gray_rd_arbiter: RTL and testbench

- Shares the single host gray-image read port (gray_addr/gray_req/gray_data) between two pixel-fetch engines, e.g. the LBP engine and a second window filter.
- Arbitrates round-robin, with optional burst lock so a requester can fetch a whole 3x3 window uninterrupted.
- Routes returned pixels to the requester that issued each read, using an in-flight tag pipeline.
- Sits between the host image memory interface and the per-engine fetch logic.

---
 rtl/gray_rd_arbiter.sv | 135 +++++++++++++
 tb/tb_gray_rd_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_rd_arbiter.sv
// Two-requester round-robin arbiter for the shared host gray-image read port,
// with burst lock, forced hand-over after MAX_BURST beats and in-order return routing.
module gray_rd_arbiter #(
    parameter int AW        = 14,
    parameter int DW        = 8,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          gray_ready,
    output logic [AW-1:0] gray_addr,
    output logic          gray_req,
    input  logic [DW-1:0] gray_data,
    input  logic          req0,
    input  logic          req1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic          lock0,
    input  logic          lock1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          busy
);

    typedef enum logic [1:0] {NONE, OWN0, OWN1} owner_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

    owner_t      owner, owner_nxt;
    logic        last_served, last_nxt;
    logic [3:0]  beat_cnt, cnt_nxt;
    logic        force_rel;
    logic        acc0, acc1;
    logic [RD_LAT:0] tag_v, tag_id;

    assign acc0 = req0 && gnt0;
    assign acc1 = req1 && gnt1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner       <= NONE;
            last_served <= 1'b1;
            beat_cnt    <= '0;
        end else begin
            owner       <= owner_nxt;
            last_served <= last_nxt;
            beat_cnt    <= cnt_nxt;
        end
    end

    always_comb begin
        owner_nxt = owner;
        last_nxt  = last_served;
        cnt_nxt   = beat_cnt;
        if (force_rel) begin
            owner_nxt = NONE;
            last_nxt  = (owner == OWN1);
            cnt_nxt   = '0;
        end else if (acc0 || acc1) begin
            if ((acc0 && lock0) || (acc1 && lock1)) begin
                owner_nxt = acc1 ? OWN1 : OWN0;
                cnt_nxt   = (beat_cnt == MAX_CNT) ? beat_cnt : beat_cnt + 4'd1;
            end else begin
                owner_nxt = NONE;
                last_nxt  = acc1;
                cnt_nxt   = '0;
            end
        end
    end

    // A saturated owner loses its grant as soon as the other side waits, even with lock high.
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        force_rel = 1'b0;
        case (owner)
            OWN0: begin
                force_rel = (beat_cnt == MAX_CNT) && req1;
                gnt0      = gray_ready && req0 && !force_rel;
            end
            OWN1: begin
                force_rel = (beat_cnt == MAX_CNT) && req0;
                gnt1      = gray_ready && req1 && !force_rel;
            end
            default: begin
                if (gray_ready) begin
                    if (req0 && req1) begin
                        gnt0 = last_served;
                        gnt1 = !last_served;
                    end else begin
                        gnt0 = req0;
                        gnt1 = req1;
                    end
                end
            end
        endcase
        if (reset) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gray_req  <= 1'b0;
            gray_addr <= '0;
            tag_v     <= '0;
            tag_id    <= '0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else begin
            gray_req <= acc0 || acc1;
            if (acc0 || acc1)
                gray_addr <= acc1 ? addr1 : addr0;
            tag_v   <= {tag_v[RD_LAT-1:0], acc0 || acc1};
            tag_id  <= {tag_id[RD_LAT-1:0], acc1};
            rvalid0 <= tag_v[RD_LAT] && !tag_id[RD_LAT];
            rvalid1 <= tag_v[RD_LAT] && tag_id[RD_LAT];
            if (tag_v[RD_LAT] && !tag_id[RD_LAT])
                rdata0 <= gray_data;
            if (tag_v[RD_LAT] && tag_id[RD_LAT])
                rdata1 <= gray_data;
        end
    end

    assign busy = (owner != NONE) || (|tag_v);

endmodule

// File: tb/tb_gray_rd_arbiter.sv
// Self-checking bench for gray_rd_arbiter: grant vector table, burst/forced-release/reset
// sequences, and a scoreboard that routes every accepted beat to its expected return.
module tb_gray_rd_arbiter;

    localparam int AW        = 14;
    localparam int DW        = 8;
    localparam int RD_LAT    = 1;
    localparam int MAX_BURST = 9;

    logic          clk = 1'b0;
    logic          reset;
    logic          gray_ready;
    logic [AW-1:0] gray_addr;
    logic          gray_req;
    logic [DW-1:0] gray_data;
    logic          req0, req1, lock0, lock1;
    logic [AW-1:0] addr0, addr1;
    logic          gnt0, gnt1, rvalid0, rvalid1, busy;
    logic [DW-1:0] rdata0, rdata1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rv_seen  = 0;

    gray_rd_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .reset(reset), .gray_ready(gray_ready),
        .gray_addr(gray_addr), .gray_req(gray_req), .gray_data(gray_data),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .lock0(lock0), .lock1(lock1), .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] host_fn(logic [AW-1:0] a);
        return a[7:0] ^ 8'hDB ^ {2'b00, a[13:8]};
    endfunction

    // Host memory model: data for the address presented is valid RD_LAT cycles later.
    logic [DW-1:0] hpipe [RD_LAT];
    always @(posedge clk) begin
        hpipe[0] <= host_fn(gray_addr);
        for (int i = 1; i < RD_LAT; i++) hpipe[i] <= hpipe[i-1];
    end
    assign gray_data = hpipe[RD_LAT-1];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic          id;
        logic [DW-1:0] data;
        int            acc_cyc;
    } exp_t;
    exp_t sb[$];

    always @(negedge clk) begin
        if (!reset) begin
            if (req0 && gnt0) sb.push_back('{1'b0, host_fn(addr0), cyc});
            if (req1 && gnt1) sb.push_back('{1'b1, host_fn(addr1), cyc});
            if (rvalid0 || rvalid1) begin
                exp_t e;
                rv_seen++;
                if (rvalid0 && rvalid1) begin
                    chk("rvalid_both", 32'd2, 32'd1);
                end else if (sb.size() == 0) begin
                    chk("rvalid_unexpected", 32'(rvalid1), 32'hFFFF);
                end else begin
                    e = sb.pop_front();
                    chk("ret_port", 32'(rvalid1), 32'(e.id));
                    chk("ret_data", 32'(rvalid1 ? rdata1 : rdata0), 32'(e.data));
                    chk("ret_latency", 32'(cyc - e.acc_cyc), 32'(RD_LAT + 2));
                end
            end
        end
    end

    typedef struct packed {
        bit r0, r1, l0, l1, rdy, g0, g1;
    } vec_t;
    vec_t tbl[18];

    task automatic drive_idle();
        req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
        gray_ready = 1'b1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        drive_idle();
        reset = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    logic [AW-1:0] win [9];
    logic          prev_acc;
    logic [AW-1:0] prev_addr;

    initial begin
        reset = 1'b1;
        drive_idle();
        addr0 = '0; addr1 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gray_addr", 32'(gray_addr), 32'h0);
        chk("rst_gray_req", 32'(gray_req), 32'h0);
        chk("rst_gnt", {30'h0, gnt0, gnt1}, 32'h0);
        chk("rst_rvalid", {30'h0, rvalid0, rvalid1}, 32'h0);
        chk("rst_rdata", {16'h0, rdata0, rdata1}, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Single requester, known pixel value.
        @(posedge clk); #1;
        req0 = 1'b1; addr0 = 14'h0081;
        @(negedge clk);
        chk("single_gnt", {30'h0, gnt0, gnt1}, 32'h2);
        @(posedge clk); #1;
        req0 = 1'b0;
        @(negedge clk);
        chk("single_gray_req", 32'(gray_req), 32'h1);
        chk("single_gray_addr", 32'(gray_addr), 32'h0081);
        chk("single_busy", 32'(busy), 32'h1);
        repeat (2) @(negedge clk);
        chk("single_rvalid", {30'h0, rvalid0, rvalid1}, 32'h2);
        chk("single_rdata", 32'(rdata0), 32'h5A);
        @(negedge clk);
        chk("single_rvalid_pulse", {30'h0, rvalid0, rvalid1}, 32'h0);
        chk("single_idle_busy", 32'(busy), 32'h0);

        // Grant table: fields r0 r1 l0 l1 rdy g0 g1; round-robin, ready-low, owner hold.
        tbl[0]  = 7'b1100110;
        tbl[1]  = 7'b1100101;
        tbl[2]  = 7'b1100110;
        tbl[3]  = 7'b1100101;
        for (int i = 4; i < 9; i++) tbl[i] = 7'b1100000;
        tbl[9]  = 7'b1100110;
        tbl[10] = 7'b0100101;
        tbl[11] = 7'b0100101;
        tbl[12] = 7'b1100110;
        tbl[13] = 7'b0000100;
        tbl[14] = 7'b1010110;
        tbl[15] = 7'b0100100;
        tbl[16] = 7'b1100110;
        tbl[17] = 7'b1100101;
        do_reset();
        prev_acc = 1'b0; prev_addr = '0;
        for (int i = 0; i < 18; i++) begin
            @(posedge clk); #1;
            req0 = tbl[i].r0; req1 = tbl[i].r1;
            lock0 = tbl[i].l0; lock1 = tbl[i].l1;
            gray_ready = tbl[i].rdy;
            addr0 = 14'(14'h0100 + i); addr1 = 14'(14'h0200 + i);
            @(negedge clk);
            chk($sformatf("tbl%0d_gnt", i), {30'h0, gnt0, gnt1}, {30'h0, tbl[i].g0, tbl[i].g1});
            chk($sformatf("tbl%0d_gray_req", i), 32'(gray_req), 32'(prev_acc));
            if (prev_acc) chk($sformatf("tbl%0d_gray_addr", i), 32'(gray_addr), 32'(prev_addr));
            prev_acc  = (tbl[i].r0 && tbl[i].g0) || (tbl[i].r1 && tbl[i].g1);
            prev_addr = tbl[i].g1 ? addr1 : addr0;
        end

        // Locked 3x3 window on requester 0 while requester 1 waits.
        do_reset();
        win = '{14'h0000, 14'h0001, 14'h0002, 14'h0080, 14'h0081,
                14'h0082, 14'h0100, 14'h0101, 14'h0102};
        for (int b = 0; b < 9; b++) begin
            @(posedge clk); #1;
            req0 = 1'b1; addr0 = win[b]; lock0 = (b < 8);
            req1 = 1'b1; addr1 = 14'h3000; lock1 = 1'b0;
            @(negedge clk);
            chk($sformatf("win_beat%0d_gnt", b), {30'h0, gnt0, gnt1}, 32'h2);
        end
        @(posedge clk); #1;
        req0 = 1'b0; lock0 = 1'b0;
        @(negedge clk);
        chk("win_handover_gnt1", {30'h0, gnt0, gnt1}, 32'h1);
        @(posedge clk); #1;
        req1 = 1'b0;

        // Forced release after MAX_BURST locked beats.
        do_reset();
        for (int b = 0; b < MAX_BURST; b++) begin
            @(posedge clk); #1;
            req0 = 1'b1; addr0 = 14'(14'h0400 + b); lock0 = 1'b1;
            req1 = 1'b1; addr1 = 14'h0555; lock1 = 1'b0;
            @(negedge clk);
            chk($sformatf("force_beat%0d_gnt", b), {30'h0, gnt0, gnt1}, 32'h2);
        end
        @(posedge clk); #1;
        addr0 = 14'h0409;
        @(negedge clk);
        chk("force_release_gap", {30'h0, gnt0, gnt1}, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("force_other_first", {30'h0, gnt0, gnt1}, 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("force_back_to_0", {30'h0, gnt0, gnt1}, 32'h2);
        for (int b = 10; b < 12; b++) begin
            @(posedge clk); #1;
            req1 = 1'b0; addr0 = 14'(14'h0400 + b); lock0 = (b < 11);
            @(negedge clk);
            chk($sformatf("force_beat%0d_gnt", b), {30'h0, gnt0, gnt1}, 32'h2);
        end
        @(posedge clk); #1;
        drive_idle();

        // Reset one cycle after an accept: nothing may come back.
        do_reset();
        @(posedge clk); #1;
        req0 = 1'b1; addr0 = 14'h0555;
        @(negedge clk);
        chk("rstmid_gnt", {30'h0, gnt0, gnt1}, 32'h2);
        @(posedge clk); #1;
        reset = 1'b1;
        sb.delete();
        rv_seen = 0;
        #1;
        chk("rstmid_gray_req", 32'(gray_req), 32'h0);
        chk("rstmid_gray_addr", 32'(gray_addr), 32'h0);
        chk("rstmid_gnt_gated", {30'h0, gnt0, gnt1}, 32'h0);
        chk("rstmid_busy", 32'(busy), 32'h0);
        @(posedge clk); #1;
        req0 = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("rstmid_no_rvalid", 32'(rv_seen), 32'h0);

        // Drain: every accepted beat must have returned.
        for (int w = 0; w < 20 && sb.size() > 0; w++) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
